// File: rtl/ahb_master_arbiter.sv
// Three-master AHB arbiter in front of a single AHB-to-APB bridge.
// Grants the bus round-robin, limits how many beats one master may hold it,
// never splits a SEQ beat, and keeps write data tied to the master that
// owned the address phase that produced it.
module ahb_master_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [2:0]  m_hbusreq,
    input  logic [95:0] m_haddr,
    input  logic [5:0]  m_htrans,
    input  logic [2:0]  m_hwrite,
    input  logic [8:0]  m_hsize,
    input  logic [95:0] m_hwdata,
    input  logic        hreadyout_b,
    output logic [2:0]  hgrant,
    output logic [1:0]  hmaster,
    output logic        s_hsel,
    output logic [31:0] s_haddr,
    output logic        s_hwrite,
    output logic [2:0]  s_hsize,
    output logic [1:0]  s_htrans,
    output logic [31:0] s_hwdata,
    output logic        s_hreadyin
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_HOLD);

    state_t      state, state_nxt;
    logic [2:0]  hgrant_nxt;
    logic [1:0]  hmaster_nxt;
    logic [1:0]  data_owner, data_owner_nxt;
    logic [1:0]  last_owner, last_owner_nxt;
    logic [7:0]  hold_cnt, hold_cnt_nxt;

    logic [31:0] own_addr;
    logic [1:0]  own_trans;
    logic        own_write;
    logic [2:0]  own_size;
    logic        own_req;
    logic [2:0]  others_req;
    logic        release_bus;

    // Round-robin pick: search begins one past the last owner.
    // Callers guarantee at least one request bit is set.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] pick;
        case (last)
            2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
        return pick;
    endfunction

    // Select the address-phase owner's controls and request bit.
    always_comb begin
        own_addr   = m_haddr[31:0];
        own_trans  = m_htrans[1:0];
        own_write  = m_hwrite[0];
        own_size   = m_hsize[2:0];
        own_req    = m_hbusreq[0];
        others_req = m_hbusreq & 3'b110;
        case (hmaster)
            2'd1: begin
                own_addr   = m_haddr[63:32];
                own_trans  = m_htrans[3:2];
                own_write  = m_hwrite[1];
                own_size   = m_hsize[5:3];
                own_req    = m_hbusreq[1];
                others_req = m_hbusreq & 3'b101;
            end
            2'd2: begin
                own_addr   = m_haddr[95:64];
                own_trans  = m_htrans[5:4];
                own_write  = m_hwrite[2];
                own_size   = m_hsize[8:6];
                own_req    = m_hbusreq[2];
                others_req = m_hbusreq & 3'b011;
            end
            default: ;
        endcase
    end

    // Owner gives up the bus when it stops requesting, or when its hold
    // budget is spent and it is not in the middle of a SEQ beat.
    always_comb begin
        release_bus = !own_req || ((hold_cnt >= MAX_CNT) && (own_trans != 2'b11));
    end

    // Next-state and arbitration decisions, only taken on ready cycles.
    always_comb begin
        state_nxt      = state;
        hgrant_nxt     = hgrant;
        hmaster_nxt    = hmaster;
        data_owner_nxt = data_owner;
        last_owner_nxt = last_owner;
        hold_cnt_nxt   = hold_cnt;
        if (hreadyout_b) begin
            data_owner_nxt = hmaster;
            case (state)
                ST_IDLE: begin
                    if (|m_hbusreq) begin
                        hmaster_nxt    = rr_pick(last_owner, m_hbusreq);
                        hgrant_nxt     = 3'b001 << rr_pick(last_owner, m_hbusreq);
                        last_owner_nxt = rr_pick(last_owner, m_hbusreq);
                        hold_cnt_nxt   = 8'd0;
                        state_nxt      = ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (own_trans[1] && (hold_cnt < MAX_CNT)) begin
                        hold_cnt_nxt = hold_cnt + 8'd1;
                    end
                    if (release_bus) begin
                        hold_cnt_nxt = 8'd0;
                        if (|others_req) begin
                            hmaster_nxt    = rr_pick(last_owner, others_req);
                            hgrant_nxt     = 3'b001 << rr_pick(last_owner, others_req);
                            last_owner_nxt = rr_pick(last_owner, others_req);
                        end else if (own_req) begin
                            last_owner_nxt = hmaster;
                        end else begin
                            hgrant_nxt = 3'b000;
                            state_nxt  = ST_IDLE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Arbiter state registers; reset abandons any transfer in flight.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state      <= ST_IDLE;
            hgrant     <= 3'b000;
            hmaster    <= 2'd0;
            data_owner <= 2'd0;
            last_owner <= 2'd2;
            hold_cnt   <= 8'd0;
        end else begin
            state      <= state_nxt;
            hgrant     <= hgrant_nxt;
            hmaster    <= hmaster_nxt;
            data_owner <= data_owner_nxt;
            last_owner <= last_owner_nxt;
            hold_cnt   <= hold_cnt_nxt;
        end
    end

    // Bridge address phase: owner's controls when owned, quiet when idle.
    always_comb begin
        s_hsel   = 1'b0;
        s_haddr  = 32'd0;
        s_hwrite = 1'b0;
        s_hsize  = 3'd0;
        s_htrans = 2'b00;
        if (state == ST_OWN) begin
            s_hsel   = (own_trans != 2'b00);
            s_haddr  = own_addr;
            s_hwrite = own_write;
            s_hsize  = own_size;
            s_htrans = own_trans;
        end
    end

    // Write data follows the data-phase owner, not the current grant.
    always_comb begin
        case (data_owner)
            2'd1:    s_hwdata = m_hwdata[63:32];
            2'd2:    s_hwdata = m_hwdata[95:64];
            default: s_hwdata = m_hwdata[31:0];
        endcase
    end

    assign s_hreadyin = hreadyout_b;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: a cycle table for the main
// arbitration flow plus hand sequences for hold limit, wait states,
// data-phase ownership and asynchronous reset.
module tb_ahb_master_arbiter;

    logic        hclk;
    logic        hreset;
    logic [2:0]  m_hbusreq;
    logic [95:0] m_haddr;
    logic [5:0]  m_htrans;
    logic [2:0]  m_hwrite;
    logic [8:0]  m_hsize;
    logic [95:0] m_hwdata;
    logic        hreadyout_b;
    logic [2:0]  hgrant;
    logic [1:0]  hmaster;
    logic        s_hsel;
    logic [31:0] s_haddr;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [1:0]  s_htrans;
    logic [31:0] s_hwdata;
    logic        s_hreadyin;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic [2:0]  req;
        logic [5:0]  htrans;
        logic        ready;
        logic [2:0]  grant;
        logic [1:0]  master;
        logic        hsel;
        logic [1:0]  strans;
        logic [31:0] haddr;
        logic [3:0]  ctrl;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs [15];

    ahb_master_arbiter #(.MAX_HOLD(8)) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .m_hbusreq   (m_hbusreq),
        .m_haddr     (m_haddr),
        .m_htrans    (m_htrans),
        .m_hwrite    (m_hwrite),
        .m_hsize     (m_hsize),
        .m_hwdata    (m_hwdata),
        .hreadyout_b (hreadyout_b),
        .hgrant      (hgrant),
        .hmaster     (hmaster),
        .s_hsel      (s_hsel),
        .s_haddr     (s_haddr),
        .s_hwrite    (s_hwrite),
        .s_hsize     (s_hsize),
        .s_htrans    (s_htrans),
        .s_hwdata    (s_hwdata),
        .s_hreadyin  (s_hreadyin)
    );

    // 10 ns clock
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // Hard stop in case anything stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs at the falling edge and settle before checking
    task automatic applyStimulus(input logic [2:0] req, input logic [5:0] htr, input logic rdy);
        @(negedge hclk);
        m_hbusreq   = req;
        m_htrans    = htr;
        hreadyout_b = rdy;
        #1;
    endtask

    task automatic doReset();
        @(negedge hclk);
        hreset      = 1'b1;
        m_hbusreq   = 3'b000;
        m_htrans    = 6'b000000;
        hreadyout_b = 1'b1;
        #1;
        checkOutput("rst_hgrant", 32'(hgrant), 32'h0);
        checkOutput("rst_hmaster", 32'(hmaster), 32'h0);
        checkOutput("rst_hsel", 32'(s_hsel), 32'h0);
        checkOutput("rst_htrans", 32'(s_htrans), 32'h0);
        checkOutput("rst_haddr", s_haddr, 32'h0);
        checkOutput("rst_hwdata", s_hwdata, 32'hA5A5_0000);
        @(negedge hclk);
        hreset = 1'b0;
    endtask

    task automatic runTable();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].req, vecs[i].htrans, vecs[i].ready);
            checkOutput($sformatf("tbl%0d_hgrant", i), 32'(hgrant), 32'(vecs[i].grant));
            checkOutput($sformatf("tbl%0d_hmaster", i), 32'(hmaster), 32'(vecs[i].master));
            checkOutput($sformatf("tbl%0d_hsel", i), 32'(s_hsel), 32'(vecs[i].hsel));
            checkOutput($sformatf("tbl%0d_htrans", i), 32'(s_htrans), 32'(vecs[i].strans));
            checkOutput($sformatf("tbl%0d_haddr", i), s_haddr, vecs[i].haddr);
            checkOutput($sformatf("tbl%0d_ctrl", i), 32'({s_hwrite, s_hsize}), 32'(vecs[i].ctrl));
            checkOutput($sformatf("tbl%0d_hwdata", i), s_hwdata, vecs[i].wdata);
            checkOutput($sformatf("tbl%0d_hreadyin", i), 32'(s_hreadyin), 32'(vecs[i].ready));
        end
    endtask

    // Master 1 runs 6-beat INCR bursts; hold budget 8 lands mid-burst, so
    // release waits for the next NONSEQ at beat 12. With a rival waiting
    // the grant then moves to master 0, otherwise master 1 keeps it.
    task automatic runHold(input bit rival);
        logic [1:0] htr1;
        logic [2:0] exp_grant;
        logic [1:0] exp_master;
        doReset();
        applyStimulus(3'b010, 6'b001000, 1'b1);
        checkOutput("hold_idle_hgrant", 32'(hgrant), 32'h0);
        for (int b = 0; b < 20; b++) begin
            htr1 = (b % 6 == 0) ? 2'b10 : 2'b11;
            applyStimulus(rival ? 3'b011 : 3'b010, {2'b00, htr1, 2'b10}, 1'b1);
            exp_grant  = (!rival || b <= 12) ? 3'b010 : 3'b001;
            exp_master = (!rival || b <= 12) ? 2'd1 : 2'd0;
            checkOutput($sformatf("hold%0d_b%0d_hgrant", rival, b), 32'(hgrant), 32'(exp_grant));
            checkOutput($sformatf("hold%0d_b%0d_hmaster", rival, b), 32'(hmaster), 32'(exp_master));
            if (exp_master == 2'd1) begin
                checkOutput($sformatf("hold%0d_b%0d_htrans", rival, b), 32'(s_htrans), 32'(htr1));
            end
        end
    endtask

    // Master 0 write stalled by three wait states while master 2 waits;
    // handover to 2 at the ready edge, write data stays master 0 one cycle,
    // then an asynchronous reset pulse between clock edges.
    task automatic runWaitAndReset();
        doReset();
        applyStimulus(3'b001, 6'b000010, 1'b1);
        checkOutput("ws_idle_hgrant", 32'(hgrant), 32'h0);
        applyStimulus(3'b101, 6'b100010, 1'b1);
        checkOutput("ws_own0_hgrant", 32'(hgrant), 32'h1);
        checkOutput("ws_own0_haddr", s_haddr, 32'h1000_0000);
        checkOutput("ws_own0_hsel", 32'(s_hsel), 32'h1);
        for (int w = 0; w < 3; w++) begin
            applyStimulus(3'b100, 6'b100000, 1'b0);
            checkOutput($sformatf("ws_wait%0d_hgrant", w), 32'(hgrant), 32'h1);
            checkOutput($sformatf("ws_wait%0d_hmaster", w), 32'(hmaster), 32'h0);
            checkOutput($sformatf("ws_wait%0d_hwdata", w), s_hwdata, 32'hA5A5_0000);
            checkOutput($sformatf("ws_wait%0d_hreadyin", w), 32'(s_hreadyin), 32'h0);
        end
        applyStimulus(3'b100, 6'b100000, 1'b1);
        checkOutput("ws_ready_hgrant", 32'(hgrant), 32'h1);
        checkOutput("ws_ready_hwdata", s_hwdata, 32'hA5A5_0000);
        applyStimulus(3'b100, 6'b100000, 1'b1);
        checkOutput("ho_hgrant", 32'(hgrant), 32'h4);
        checkOutput("ho_hmaster", 32'(hmaster), 32'h2);
        checkOutput("ho_haddr", s_haddr, 32'h1200_0000);
        checkOutput("ho_hwdata_old", s_hwdata, 32'hA5A5_0000);
        applyStimulus(3'b100, 6'b100000, 1'b1);
        checkOutput("ho_hwdata_new", s_hwdata, 32'h2222_2222);
        checkOutput("ho_hsel", 32'(s_hsel), 32'h1);
        #2;
        hreset = 1'b1;
        #1;
        checkOutput("arst_hgrant", 32'(hgrant), 32'h0);
        checkOutput("arst_hsel", 32'(s_hsel), 32'h0);
        checkOutput("arst_htrans", 32'(s_htrans), 32'h0);
        checkOutput("arst_hmaster", 32'(hmaster), 32'h0);
        @(negedge hclk);
        hreset = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        hreset       = 1'b1;
        m_hbusreq    = 3'b000;
        m_htrans     = 6'b000000;
        hreadyout_b  = 1'b1;
        m_haddr      = {32'h1200_0000, 32'h1100_0000, 32'h1000_0000};
        m_hwdata     = {32'h2222_2222, 32'h1111_1111, 32'hA5A5_0000};
        m_hwrite     = 3'b101;
        m_hsize      = {3'b000, 3'b001, 3'b010};

        //            req     htrans     rdy   grant   mst  hsel strans haddr          ctrl     wdata
        vecs[0]  = '{3'b111, 6'b101010, 1'b1, 3'b000, 2'd0, 1'b0, 2'b00, 32'h0,         4'b0000, 32'hA5A5_0000};
        vecs[1]  = '{3'b111, 6'b101010, 1'b1, 3'b001, 2'd0, 1'b1, 2'b10, 32'h1000_0000, 4'b1010, 32'hA5A5_0000};
        vecs[2]  = '{3'b110, 6'b101000, 1'b1, 3'b001, 2'd0, 1'b0, 2'b00, 32'h1000_0000, 4'b1010, 32'hA5A5_0000};
        vecs[3]  = '{3'b110, 6'b101010, 1'b1, 3'b010, 2'd1, 1'b1, 2'b10, 32'h1100_0000, 4'b0001, 32'hA5A5_0000};
        vecs[4]  = '{3'b100, 6'b100010, 1'b1, 3'b010, 2'd1, 1'b0, 2'b00, 32'h1100_0000, 4'b0001, 32'h1111_1111};
        vecs[5]  = '{3'b100, 6'b101010, 1'b1, 3'b100, 2'd2, 1'b1, 2'b10, 32'h1200_0000, 4'b1000, 32'h1111_1111};
        vecs[6]  = '{3'b000, 6'b001010, 1'b1, 3'b100, 2'd2, 1'b0, 2'b00, 32'h1200_0000, 4'b1000, 32'h2222_2222};
        vecs[7]  = '{3'b000, 6'b001010, 1'b1, 3'b000, 2'd2, 1'b0, 2'b00, 32'h0,         4'b0000, 32'h2222_2222};
        vecs[8]  = '{3'b110, 6'b101010, 1'b1, 3'b000, 2'd2, 1'b0, 2'b00, 32'h0,         4'b0000, 32'h2222_2222};
        vecs[9]  = '{3'b110, 6'b101010, 1'b1, 3'b010, 2'd1, 1'b1, 2'b10, 32'h1100_0000, 4'b0001, 32'h2222_2222};
        vecs[10] = '{3'b100, 6'b100010, 1'b0, 3'b010, 2'd1, 1'b0, 2'b00, 32'h1100_0000, 4'b0001, 32'h1111_1111};
        vecs[11] = '{3'b100, 6'b100010, 1'b0, 3'b010, 2'd1, 1'b0, 2'b00, 32'h1100_0000, 4'b0001, 32'h1111_1111};
        vecs[12] = '{3'b100, 6'b100010, 1'b1, 3'b010, 2'd1, 1'b0, 2'b00, 32'h1100_0000, 4'b0001, 32'h1111_1111};
        vecs[13] = '{3'b100, 6'b101010, 1'b1, 3'b100, 2'd2, 1'b1, 2'b10, 32'h1200_0000, 4'b1000, 32'h1111_1111};
        vecs[14] = '{3'b000, 6'b001010, 1'b1, 3'b100, 2'd2, 1'b0, 2'b00, 32'h1200_0000, 4'b1000, 32'h2222_2222};

        repeat (2) @(negedge hclk);
        doReset();
        runTable();
        runHold(1'b0);
        runHold(1'b1);
        runWaitAndReset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: max accepted transfers per grant before forced re-arbitration; legal range 1..255.
REQ-002 hclk  in  1  sole clock; all state updates on rising edge.
REQ-003 hreset  in  1  reset, asynchronous, active-high.
REQ-004 m_hbusreq  in  3  bus request, bit i = master i.
REQ-005 m_haddr  in  96  master i address at [32i+31:32i].
REQ-006 m_htrans  in  6  master i htrans at [2i+1:2i].
REQ-007 m_hwrite  in  3  master i hwrite at bit i.
REQ-008 m_hsize  in  9  master i hsize at [3i+2:3i].
REQ-009 m_hwdata  in  96  master i write data at [32i+31:32i].
REQ-010 hreadyout_b  in  1  Hreadyout returned by the AHB-to-APB bridge.
REQ-011 hgrant  out  3  one-hot grant, registered.
REQ-012 hmaster  out  2  index of address-phase owner, registered.
REQ-013 s_hsel  out  1  bridge hsel.
REQ-014 s_haddr / s_hwrite / s_hsize  out  32/1/3  bridge address-phase controls.
REQ-015 s_htrans  out  2  bridge htrans.
REQ-016 s_hwdata  out  32  bridge write data, data-phase owner's m_hwdata.
REQ-017 s_hreadyin  out  1  equals hreadyout_b, combinational; also fanned back as the ready seen by all masters.

Function
REQ-018 States: IDLE (no owner) and OWN (one master granted); arbitration decisions are taken only in cycles with hreadyout_b=1, all state frozen otherwise.
REQ-019 IDLE: s_htrans=2'b00, s_hsel=0, s_haddr=0, s_hwrite=0, s_hsize=0; if any m_hbusreq bit set, next edge: hgrant=winner, hmaster=winner index, hold count=0, go OWN.
REQ-020 Winner is round-robin: search starts at (last_owner+1) mod 3, first requesting index wins; last_owner updates to each new owner.
REQ-021 OWN: s_haddr/s_htrans/s_hwrite/s_hsize = owner's slice; s_hsel=1 when owner htrans is 2'b01, 2'b10 or 2'b11, else 0.
REQ-022 Hold count increments (saturating at MAX_HOLD) on each hreadyout_b=1 cycle where owner htrans is 2'b10 or 2'b11.
REQ-023 Release in OWN on hreadyout_b=1 when owner's m_hbusreq=0, or when hold count has reached MAX_HOLD and owner htrans is not 2'b11 (SEQ beat is never split).
REQ-024 On release: if another master requests, grant it at the same edge (OWN->OWN, count=0, no idle cycle); if only the releasing owner still requests (MAX_HOLD case) re-grant it with count=0; if none, go IDLE, hgrant=000.
REQ-025 Data-phase owner register loads hmaster on every hreadyout_b=1 edge; s_hwdata selects that register; it is unaffected by grant changes until the pending data phase completes.
REQ-026 Requests dropped/raised while hreadyout_b=0 have no effect until the next ready cycle.
REQ-027 Simultaneous requests from all three in IDLE after reset grant master 0, then 1, then 2 on successive releases.

Reset
REQ-028 While hreset=1: state=IDLE, hgrant=000, hmaster=0, data owner=0, last_owner=2, hold count=0; address-phase outputs at IDLE values; reset asserted mid-transfer abandons it immediately, no bridge handshake completed.

Verification
REQ-029 Reset, m_hbusreq=3'b111, hreadyout_b=1 -> grants 001,010,100 in order as each owner drops request; s_htrans 00 before first grant.
REQ-030 Master 1 alone, 20 NONSEQ/SEQ beats, MAX_HOLD=8, ready=1 -> re-grant after 8 accepted beats, never between SEQ beats, hgrant stays 010.
REQ-031 Master 0 owns, writes 0xA5A5_0000 data phase, hreadyout_b=0 three cycles while master 2 requests -> hgrant/hmaster frozen; s_hwdata=master 0 data until ready; grant moves to 100 at ready edge.
REQ-032 Handover 0->2 with back-to-back transfers -> s_haddr switches to master 2 same edge, s_hwdata still master 0 one cycle, then master 2.
REQ-033 hreset pulsed asynchronously mid-OWN -> hgrant=000, s_hsel=0 immediately, before next hclk edge.
